// File: rtl/logic_capture_engine.sv
// Transition-capture engine for the logic-analyzer datapath.
// It synchronises CH_W probe channels and writes one BRAM entry for each input change into a
// circular buffer of 2^ADDR_W entries. Capture stops after a pre/post-trigger split around an
// accepted edge-plus-pattern trigger.
// Optional feature: define LOGIC_CAPTURE_TIMESTAMP_EN to store a delta timestamp with each entry.
// With that macro, an entry is also forced once the delta counter saturates.
module logic_capture_engine #(
  parameter int unsigned CH_W   = 8,
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned TS_W   = 16
) (
  input  logic                                       clk,
  input  logic                                       resetn,
  input  logic                                       start,
  input  logic                                       abort,
  input  logic [CH_W-1:0]                            trig_mask,
  input  logic [CH_W-1:0]                            trig_value,
  input  logic [((CH_W > 1) ? $clog2(CH_W) : 1)-1:0] edge_ch,
  input  logic [1:0]                                 edge_mode,
  input  logic [ADDR_W-1:0]                          pre_count,
  input  logic [CH_W-1:0]                            datain,
  output logic                                       bram_en,
  output logic                                       bram_we,
  output logic [ADDR_W-1:0]                          bram_addr,
  output logic [CH_W+TS_W-1:0]                       bram_din,
  output logic                                       busy,
  output logic                                       pre_met,
  output logic                                       triggered,
  output logic                                       done,
  output logic [ADDR_W-1:0]                          trig_addr,
  output logic [ADDR_W-1:0]                          wr_ptr
);

  localparam int unsigned EdgeW = (CH_W > 1) ? $clog2(CH_W) : 1;
  localparam int unsigned CntW  = ADDR_W + 1;
  localparam logic [CntW-1:0] Depth = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {StIdle, StArmed, StPost, StDone} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     sync1_q, sync2_q, cur_q, prev_q;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic [CntW-1:0]     wcnt_q, wcnt_d;
  logic [CntW-1:0]     post_cnt_q, post_cnt_d;
  logic                pre_met_q, pre_met_d;
  logic                triggered_q, triggered_d;
  logic [CH_W-1:0]     cfg_mask_q, cfg_mask_d;
  logic [CH_W-1:0]     cfg_value_q, cfg_value_d;
  logic [EdgeW-1:0]    cfg_ch_q, cfg_ch_d;
  logic [1:0]          cfg_mode_q, cfg_mode_d;
  logic [CntW-1:0]     cfg_pre_q, cfg_pre_d;
  logic [CntW-1:0]     cfg_post_q, cfg_post_d;

  logic                busy_w, chg, edge_ok, pat_ok, hit, pre_ok, accept, base_wr, wr_en;
  logic                ts_force;
  logic [TS_W-1:0]     ts_field;

`ifdef LOGIC_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0]     delta_q, delta_d;
  assign ts_force = busy_w && (delta_q == '1);
  assign ts_field = delta_q;
`else
  assign ts_force = 1'b0;
  assign ts_field = '0;
`endif

  assign busy_w = (state_q == StArmed) || (state_q == StPost);

  // Trigger evaluation and the single-write-per-cycle decision.
  always_comb begin
    chg = (cur_q != prev_q);
    edge_ok = 1'b0;
    unique case (cfg_mode_q)
      2'b00: edge_ok = 1'b1;
      2'b01: edge_ok = cur_q[cfg_ch_q] & ~prev_q[cfg_ch_q];
      2'b10: edge_ok = ~cur_q[cfg_ch_q] & prev_q[cfg_ch_q];
      2'b11: edge_ok = cur_q[cfg_ch_q] ^ prev_q[cfg_ch_q];
      default: edge_ok = 1'b0;
    endcase
    pat_ok  = &((cur_q ~^ cfg_value_q) | ~cfg_mask_q);
    hit     = edge_ok & pat_ok;
    base_wr = chg | ts_force;
    // Counting this cycle's change write lets a hit land on the cycle pre_met sets.
    pre_ok  = pre_met_q | ((wcnt_q + CntW'(base_wr)) >= cfg_pre_q);
    accept  = (state_q == StArmed) && hit && pre_ok && !abort;
    wr_en   = busy_w && !abort && (base_wr || accept);
  end

  // Next-state for the capture controller, counters and latched config.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    trig_addr_d = trig_addr_q;
    wcnt_d      = wcnt_q;
    post_cnt_d  = post_cnt_q;
    pre_met_d   = pre_met_q;
    triggered_d = triggered_q;
    cfg_mask_d  = cfg_mask_q;
    cfg_value_d = cfg_value_q;
    cfg_ch_d    = cfg_ch_q;
    cfg_mode_d  = cfg_mode_q;
    cfg_pre_d   = cfg_pre_q;
    cfg_post_d  = cfg_post_q;
`ifdef LOGIC_CAPTURE_TIMESTAMP_EN
    delta_d     = delta_q;
    if (busy_w) delta_d = wr_en ? '0 : delta_q + TS_W'(1);
`endif

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      wcnt_d   = (wcnt_q == Depth) ? wcnt_q : wcnt_q + CntW'(1);
    end
    if (busy_w && !abort) pre_met_d = pre_met_q | (wcnt_d >= cfg_pre_q);

    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            cfg_mask_d  = trig_mask;
            cfg_value_d = trig_value;
            cfg_ch_d    = edge_ch;
            cfg_mode_d  = edge_mode;
            // An ADDR_W-bit pre_count can never exceed DEPTH-1, so no clamp is needed.
            cfg_pre_d   = {1'b0, pre_count};
            cfg_post_d  = Depth - {1'b0, pre_count};
            wr_ptr_d    = '0;
            trig_addr_d = '0;
            wcnt_d      = '0;
            post_cnt_d  = '0;
            pre_met_d   = 1'b0;
            triggered_d = 1'b0;
`ifdef LOGIC_CAPTURE_TIMESTAMP_EN
            delta_d     = '0;
`endif
            state_d     = StArmed;
          end
        end
        StArmed: begin
          if (accept) begin
            triggered_d = 1'b1;
            trig_addr_d = wr_ptr_q;
            post_cnt_d  = CntW'(1);
            state_d     = (cfg_post_q == CntW'(1)) ? StDone : StPost;
          end
        end
        StPost: begin
          if (wr_en) begin
            post_cnt_d = post_cnt_q + CntW'(1);
            if (post_cnt_d == cfg_post_q) state_d = StDone;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Two-stage synchroniser followed by current/previous sample registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cur_q   <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= datain;
      sync2_q <= sync1_q;
      cur_q   <= sync2_q;
      prev_q  <= cur_q;
    end
  end

  // Controller state, counters and latched configuration.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      trig_addr_q <= '0;
      wcnt_q      <= '0;
      post_cnt_q  <= '0;
      pre_met_q   <= 1'b0;
      triggered_q <= 1'b0;
      cfg_mask_q  <= '0;
      cfg_value_q <= '0;
      cfg_ch_q    <= '0;
      cfg_mode_q  <= '0;
      cfg_pre_q   <= '0;
      cfg_post_q  <= '0;
`ifdef LOGIC_CAPTURE_TIMESTAMP_EN
      delta_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      trig_addr_q <= trig_addr_d;
      wcnt_q      <= wcnt_d;
      post_cnt_q  <= post_cnt_d;
      pre_met_q   <= pre_met_d;
      triggered_q <= triggered_d;
      cfg_mask_q  <= cfg_mask_d;
      cfg_value_q <= cfg_value_d;
      cfg_ch_q    <= cfg_ch_d;
      cfg_mode_q  <= cfg_mode_d;
      cfg_pre_q   <= cfg_pre_d;
      cfg_post_q  <= cfg_post_d;
`ifdef LOGIC_CAPTURE_TIMESTAMP_EN
      delta_q     <= delta_d;
`endif
    end
  end

  // The write strobe is decoded from registered state so abort and reset gate it at once.
  assign bram_en   = wr_en;
  assign bram_we   = wr_en;
  assign bram_addr = wr_ptr_q;
  assign bram_din  = {ts_field, cur_q};
  assign busy      = busy_w;
  assign pre_met   = pre_met_q;
  assign triggered = triggered_q;
  assign done      = (state_q == StDone);
  assign trig_addr = trig_addr_q;
  assign wr_ptr    = wr_ptr_q;

endmodule

// File: tb/tb_logic_capture_engine.sv
// Self-checking bench for logic_capture_engine (CH_W=8, ADDR_W=4, TS_W=16).
module tb_logic_capture_engine;
  localparam int unsigned CH_W   = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned TS_W   = 16;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              resetn, start, abort;
  logic [7:0]        trig_mask, trig_value, datain;
  logic [2:0]        edge_ch;
  logic [1:0]        edge_mode;
  logic [3:0]        pre_count;
  logic              bram_en, bram_we, busy, pre_met, triggered, done;
  logic [3:0]        bram_addr, trig_addr, wr_ptr;
  logic [23:0]       bram_din;

  int n_checks = 0;
  int n_pass   = 0;

  // Observed writes: {en, addr[3:0], din[23:0]}.
  logic [28:0] wq[$];

  logic_capture_engine #(.CH_W(CH_W), .ADDR_W(ADDR_W), .TS_W(TS_W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .trig_mask(trig_mask), .trig_value(trig_value), .edge_ch(edge_ch),
    .edge_mode(edge_mode), .pre_count(pre_count), .datain(datain),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .busy(busy), .pre_met(pre_met), .triggered(triggered), .done(done),
    .trig_addr(trig_addr), .wr_ptr(wr_ptr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resetn && bram_we) wq.push_back({bram_en, bram_addr, bram_din});
  end

  function automatic logic [41:0] out_vec();
    return {bram_en, bram_we, bram_addr, bram_din, busy, pre_met, triggered, done,
            trig_addr, wr_ptr};
  endfunction

  function automatic bit pat_match(logic [7:0] v, logic [7:0] m, logic [7:0] t);
    return ((v ~^ t) | ~m) == 8'hff;
  endfunction

  function automatic bit edge_match(logic [7:0] p, logic [7:0] v, logic [2:0] ch,
                                    logic [1:0] mode);
    case (mode)
      2'd0: return 1'b1;
      2'd1: return !p[ch] && v[ch];
      2'd2: return p[ch] && !v[ch];
      default: return p[ch] != v[ch];
    endcase
  endfunction

  // Drive a new probe value and wait until its write (if any) has completed.
  task automatic apply(input logic [7:0] v);
    @(posedge clk); #1 datain = v;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] pc, input logic [1:0] mode, input logic [2:0] ch,
                          input logic [7:0] mask, input logic [7:0] val);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wq.delete();
    pre_count = pc; edge_mode = mode; edge_ch = ch; trig_mask = mask; trig_value = val;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; abort = 1'b0; datain = 8'h00;
    trig_mask = '0; trig_value = '0; edge_ch = '0; edge_mode = '0; pre_count = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_vec() !== 42'd0) $display("FAIL reset_outputs got %h want 0", out_vec());
    else n_pass++;
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_vec() !== 42'd0) $display("FAIL idle_outputs got %h want 0", out_vec());
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [7:0] exp_s[18];
    logic [7:0] vals[18] = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12, 8'd13, 8'd20, 8'd21,
                             8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd29, 8'd30};
    exp_s = vals;
    apply(8'h00);
    do_start(4'd4, 2'b01, 3'd0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) apply(vals[i]);
    n_checks++;
    if (pre_met !== 1'b0 || wr_ptr !== 4'd3)
      $display("FAIL basic_pre3 pre_met=%b wr_ptr=%0d want 0/3", pre_met, wr_ptr);
    else n_pass++;
    // start while busy with a config that would trigger at once must be ignored
    @(posedge clk); #1 start = 1'b1; pre_count = 4'd0; edge_mode = 2'b00;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, pre_met, triggered, wr_ptr} !== {3'b100, 4'd3})
      $display("FAIL start_while_busy got %b%b%b ptr %0d want 100 ptr 3",
               busy, pre_met, triggered, wr_ptr);
    else n_pass++;
    apply(vals[3]);
    n_checks++;
    if (pre_met !== 1'b1) $display("FAIL basic_pre4 pre_met=%b want 1", pre_met);
    else n_pass++;
    apply(vals[4]); apply(vals[5]);
    n_checks++;
    if (triggered !== 1'b0) $display("FAIL basic_no_trig triggered=%b want 0", triggered);
    else n_pass++;
    apply(vals[6]);
    n_checks++;
    if (triggered !== 1'b1 || trig_addr !== 4'd6)
      $display("FAIL basic_trig triggered=%b trig_addr=%0d want 1/6", triggered, trig_addr);
    else n_pass++;
    for (int i = 7; i < 18; i++) apply(vals[i]);
    n_checks++;
    if ({done, busy, wr_ptr} !== {2'b10, 4'd2} || wq.size() != 18)
      $display("FAIL basic_done done=%b busy=%b wr_ptr=%0d writes=%0d want 1/0/2/18",
               done, busy, wr_ptr, wq.size());
    else n_pass++;
    for (int i = 0; i < 18 && i < wq.size(); i++) begin
      n_checks++;
      if (wq[i][28] !== 1'b1 || wq[i][27:24] !== 4'(i % DEPTH) || wq[i][7:0] !== exp_s[i])
        $display("FAIL basic_write[%0d] got en=%b addr=%0d s=%h want 1/%0d/%h", i,
                 wq[i][28], wq[i][27:24], wq[i][7:0], i % DEPTH, exp_s[i]);
      else n_pass++;
    end
    apply(8'd31);
    n_checks++;
    if (wq.size() != 18 || done !== 1'b1)
      $display("FAIL done_hold writes=%0d done=%b want 18/1", wq.size(), done);
    else n_pass++;
  endtask

  task automatic test_pre_gate();
    apply(8'h00);
    do_start(4'd4, 2'b01, 3'd0, 8'h00, 8'h00);
    apply(8'd1); apply(8'd2); apply(8'd3);
    n_checks++;
    if (triggered !== 1'b0 || wr_ptr !== 4'd3)
      $display("FAIL pre_gate_early triggered=%b wr_ptr=%0d want 0/3", triggered, wr_ptr);
    else n_pass++;
    apply(8'd4);
    apply(8'd5);
    n_checks++;
    if (triggered !== 1'b1 || trig_addr !== 4'd4)
      $display("FAIL pre_gate_late triggered=%b trig_addr=%0d want 1/4", triggered, trig_addr);
    else n_pass++;
  endtask

  task automatic test_pattern_edge();
    apply(8'h38);
    do_start(4'd0, 2'b10, 3'd3, 8'h30, 8'h10);
    apply(8'h30);
    n_checks++;
    if (triggered !== 1'b0 || wr_ptr !== 4'd1)
      $display("FAIL pattern_block triggered=%b wr_ptr=%0d want 0/1", triggered, wr_ptr);
    else n_pass++;
    apply(8'h18);
    apply(8'h10);
    n_checks++;
    if (triggered !== 1'b1 || trig_addr !== 4'd2)
      $display("FAIL pattern_hit triggered=%b trig_addr=%0d want 1/2", triggered, trig_addr);
    else n_pass++;
  endtask

  task automatic test_idle_timestamp();
    apply(8'h5a);
    do_start(4'd0, 2'b01, 3'd0, 8'h00, 8'h00);
    repeat (70000) @(posedge clk);
    #1;
`ifdef LOGIC_CAPTURE_TIMESTAMP_EN
    n_checks++;
    if (wq.size() != 1) $display("FAIL idle_forced writes=%0d want 1", wq.size());
    else n_pass++;
    if (wq.size() >= 1) begin
      n_checks++;
      if (wq[0][23:0] !== 24'hffff5a || wq[0][27:24] !== 4'd0)
        $display("FAIL idle_ts got din=%h addr=%0d want ffff5a/0", wq[0][23:0], wq[0][27:24]);
      else n_pass++;
    end
`else
    n_checks++;
    if (wq.size() != 0) $display("FAIL idle_no_write writes=%0d want 0", wq.size());
    else n_pass++;
`endif
  endtask

  task automatic test_abort();
    apply(8'h00);
    do_start(4'd0, 2'b01, 3'd0, 8'h00, 8'h00);
    apply(8'h01);
    apply(8'h02);
    @(posedge clk); #1 datain = 8'h04;
    repeat (3) @(posedge clk);
    #1 abort = 1'b1; start = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bram_we !== 1'b0) $display("FAIL abort_no_write bram_we=%b want 0", bram_we);
    else n_pass++;
    @(posedge clk); #1 abort = 1'b0; start = 1'b0;
    n_checks++;
    if ({busy, done, wr_ptr, trig_addr} !== {2'b00, 4'd2, 4'd0} || wq.size() != 2)
      $display("FAIL abort_state busy=%b done=%b wr_ptr=%0d trig_addr=%0d writes=%0d want 0/0/2/0/2",
               busy, done, wr_ptr, trig_addr, wq.size());
    else n_pass++;
    do_start(4'd0, 2'b01, 3'd0, 8'h00, 8'h00);
    n_checks++;
    if ({busy, wr_ptr, triggered} !== {1'b1, 4'd0, 1'b0})
      $display("FAIL abort_restart busy=%b wr_ptr=%0d triggered=%b want 1/0/0",
               busy, wr_ptr, triggered);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    apply(8'h00);
    do_start(4'd0, 2'b01, 3'd0, 8'h00, 8'h00);
    @(posedge clk); #1 datain = 8'h02;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (bram_we !== 1'b1) $display("FAIL reset_mid_pre bram_we=%b want 1", bram_we);
    else n_pass++;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (out_vec() !== 42'd0) $display("FAIL reset_mid_async got %h want 0", out_vec());
    else n_pass++;
    @(posedge clk); #3 resetn = 1'b1;
    apply(8'h02);
    do_start(4'd0, 2'b01, 3'd0, 8'h00, 8'h00);
    apply(8'h03);
    n_checks++;
    if ({triggered, trig_addr, wr_ptr, busy} !== {1'b1, 4'd0, 4'd1, 1'b1} || wq.size() != 1)
      $display("FAIL reset_mid_recover trig=%b taddr=%0d ptr=%0d busy=%b writes=%0d want 1/0/1/1/1",
               triggered, trig_addr, wr_ptr, busy, wq.size());
    else n_pass++;
  endtask

  // Randomised captures checked against a sample-list model of the capture rules.
  task automatic test_random();
    logic [7:0] v0, p, v, mask, tval;
    logic [3:0] pc;
    logic [1:0] mode;
    logic [2:0] ch;
    int         pre, post, cnt, pcnt, tidx;
    bit         trig, fin;
    logic [7:0] exp_q[$];
    for (int r = 0; r < 8; r++) begin
      pc = 4'($urandom_range(0, 15));
      mode = 2'($urandom_range(0, 3));
      ch = 3'($urandom_range(0, 7));
      mask = 8'($urandom & $urandom);
      tval = 8'($urandom);
      v0 = 8'($urandom);
      apply(v0);
      do_start(pc, mode, ch, mask, tval);
      pre = int'(pc); post = DEPTH - pre;
      cnt = 0; pcnt = 0; tidx = 0; trig = 0; fin = 0;
      exp_q.delete();
      // Pattern-only with no pre requirement fires on the held sample immediately.
      if (mode == 2'd0 && pat_match(v0, mask, tval) && pre == 0) begin
        exp_q.push_back(v0); cnt = 1; trig = 1; tidx = 0; pcnt = 1;
        if (pcnt == post) fin = 1;
      end
      p = v0;
      for (int k = 0; k < 40; k++) begin
        v = 8'($urandom);
        if (v == p) v = v ^ 8'h01;
        apply(v);
        if (!fin) begin
          exp_q.push_back(v);
          cnt++;
          if (trig) begin
            pcnt++;
            if (pcnt == post) fin = 1;
          end else if (edge_match(p, v, ch, mode) && pat_match(v, mask, tval) && cnt >= pre) begin
            trig = 1; tidx = cnt - 1; pcnt = 1;
            if (pcnt == post) fin = 1;
          end
        end
        p = v;
      end
      n_checks++;
      if (wq.size() != exp_q.size())
        $display("FAIL rand%0d_count writes=%0d want %0d", r, wq.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < wq.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (wq[i][27:24] !== 4'(i % DEPTH) || wq[i][7:0] !== exp_q[i])
          $display("FAIL rand%0d_write[%0d] addr=%0d s=%h want %0d/%h", r, i, wq[i][27:24],
                   wq[i][7:0], i % DEPTH, exp_q[i]);
        else n_pass++;
      end
      n_checks++;
      if ({triggered, done, busy, pre_met, wr_ptr} !==
          {trig, fin, !fin, (cnt >= pre), 4'(exp_q.size() % DEPTH)})
        $display("FAIL rand%0d_status trig=%b done=%b busy=%b pre=%b ptr=%0d want %b/%b/%b/%b/%0d",
                 r, triggered, done, busy, pre_met, wr_ptr, trig, fin, !fin, (cnt >= pre),
                 exp_q.size() % DEPTH);
      else n_pass++;
      if (trig) begin
        n_checks++;
        if (trig_addr !== 4'(tidx % DEPTH))
          $display("FAIL rand%0d_trig_addr got %0d want %0d", r, trig_addr, tidx % DEPTH);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pre_gate();
    test_pattern_edge();
    test_abort();
    test_reset_mid();
    test_random();
    test_idle_timestamp();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
